// File: rtl/sps_pkg.sv
// Shared encodings for the rock-paper-scissors move transmitter:
// move codes, tx FSM states and frame geometry.
package sps_pkg;

  localparam logic [1:0] MOVE_ROCK     = 2'b00;
  localparam logic [1:0] MOVE_PAPER    = 2'b01;
  localparam logic [1:0] MOVE_SCISSORS = 2'b10;
  localparam logic [1:0] MOVE_INVALID  = 2'b11;

  localparam int FRAME_BITS = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    D0    = 3'd2,
    D1    = 3'd3,
    PID   = 3'd4,
    PAR   = 3'd5,
    STOP  = 3'd6
  } tx_state_e;

  // Even parity over the three payload bits of a frame.
  function automatic logic even_parity(input logic [1:0] mv, input logic pid);
    return mv[0] ^ mv[1] ^ pid;
  endfunction

endpackage

// File: rtl/sps_bit_timer.sv
// Baud counter: bit_end pulses on the last cycle of each CLKS_PER_BIT-long bit.
// restart zeroes the count so every state starts a fresh bit period.
module sps_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_end
);

  logic [7:0] count;

  assign bit_end = (count == 8'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'd0;
    end else if (restart || bit_end) begin
      count <= 8'd0;
    end else begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/sps_move_tx.sv
// Serialises one player move into a start/move0/move1/pid/parity/stop frame
// towards the game core; illegal move codes are dropped with an error pulse.
module sps_move_tx
  import sps_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       move_valid,
  input  logic [1:0] move,
  input  logic       player_id,
  output logic       move_ready,
  output logic       tx,
  output logic       busy,
  output logic       frame_done,
  output logic       err_invalid
);

  tx_state_e  state;
  tx_state_e  state_next;
  logic [1:0] move_q;
  logic       pid_q;
  logic       bit_end;
  logic       restart;
  logic       accept;
  logic       tx_next;

  assign move_ready = (state == IDLE) && !rst;
  assign accept     = move_valid && move_ready;
  assign busy       = (state != IDLE);
  assign frame_done = (state == STOP) && bit_end;

  // Holding the timer in restart while idle keeps the first bit full length.
  assign restart = (state_next != state) || (state == IDLE);

  sps_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .bit_end(bit_end)
  );

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept && (move != MOVE_INVALID)) state_next = START;
      START:   if (bit_end) state_next = D0;
      D0:      if (bit_end) state_next = D1;
      D1:      if (bit_end) state_next = PID;
      PID:     if (bit_end) state_next = PAR;
      PAR:     if (bit_end) state_next = STOP;
      STOP:    if (bit_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // tx is registered from the upcoming state so the line changes on the edge.
  always_comb begin
    tx_next = 1'b1;
    unique case (state_next)
      START:   tx_next = 1'b0;
      D0:      tx_next = move_q[0];
      D1:      tx_next = move_q[1];
      PID:     tx_next = pid_q;
      PAR:     tx_next = even_parity(move_q, pid_q);
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tx          <= 1'b1;
      move_q      <= 2'b00;
      pid_q       <= 1'b0;
      err_invalid <= 1'b0;
    end else begin
      state       <= state_next;
      tx          <= tx_next;
      err_invalid <= accept && (move == MOVE_INVALID);
      if (accept) begin
        move_q <= move;
        pid_q  <= player_id;
      end
    end
  end

endmodule

// File: tb/tb_sps_move_tx.sv
// Self-checking bench for sps_move_tx: frame-position reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_sps_move_tx;
  import sps_pkg::*;

  localparam int CPB       = 4;
  localparam int FRAME_LEN = FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       move_valid = 1'b0;
  logic [1:0] move = 2'b00;
  logic       player_id = 1'b0;
  logic       move_ready;
  logic       tx;
  logic       busy;
  logic       frame_done;
  logic       err_invalid;

  int checks = 0;
  int errors = 0;
  int done_count = 0;
  logic check_en = 1'b0;

  sps_move_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .move_valid (move_valid),
    .move       (move),
    .player_id  (player_id),
    .move_ready (move_ready),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done),
    .err_invalid(err_invalid)
  );

  always #5 clk = ~clk;

  // Reference: pos is the cycle index within the current frame, -1 when idle.
  int         pos = -1;
  logic [5:0] frame_bits = 6'b111111;
  logic       exp_err = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pos     <= -1;
      exp_err <= 1'b0;
    end else begin
      exp_err <= 1'b0;
      if (pos >= 0) begin
        pos <= (pos == FRAME_LEN - 1) ? -1 : pos + 1;
      end else if (move_valid) begin
        if (move == 2'b11) begin
          exp_err <= 1'b1;
        end else begin
          pos        <= 0;
          frame_bits <= {1'b1, move[0] ^ move[1] ^ player_id, player_id,
                         move[1], move[0], 1'b0};
        end
      end
    end
  end

  function automatic logic model_tx(input int p, input logic [5:0] b);
    if (p < 0) return 1'b1;
    return b[p / CPB];
  endfunction

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] m, input logic p);
    move_valid = v;
    move       = m;
    player_id  = p;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("tx", tx, model_tx(pos, frame_bits));
      checkOutput("busy", busy, pos >= 0);
      checkOutput("move_ready", move_ready, (pos < 0) && !rst);
      checkOutput("frame_done", frame_done, pos == FRAME_LEN - 1);
      checkOutput("err_invalid", err_invalid, exp_err);
    end
  end

  always @(negedge clk) begin
    if (frame_done === 1'b1) done_count++;
  end

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      step();
      if (move_ready === 1'b1) ok = 1'b1;
    end
    checkOutput("idle_timeout", ok, 1'b1);
  endtask

  // Sends one frame from cycle 0 and compares the sampled bits to a literal.
  task automatic run_literal(input logic [1:0] m, input logic p,
                             input logic [5:0] exp_bits, input bit disturb,
                             input string tag);
    logic rec_tx[27];
    logic rec_done[27];
    logic rec_ready[27];
    wait_idle();
    applyStimulus(1'b1, m, p);
    for (int c = 1; c <= 26; c++) begin
      step();
      if (c == 1) applyStimulus(1'b0, m, p);
      if (disturb && c == 5) applyStimulus(1'b1, 2'(~m), ~p);
      if (disturb && c == 6) applyStimulus(1'b0, m, p);
      @(negedge clk);
      rec_tx[c]    = tx;
      rec_done[c]  = frame_done;
      rec_ready[c] = move_ready;
    end
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < CPB; k++)
        checkOutput({tag, "_bit"}, rec_tx[1 + i * CPB + k], exp_bits[i]);
    end
    for (int c = 1; c <= 26; c++)
      checkOutput({tag, "_done"}, rec_done[c], c == 24);
    checkOutput({tag, "_ready25"}, rec_ready[25], 1'b1);
    checkOutput({tag, "_idle26"}, rec_tx[26], 1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int snap;

    applyStimulus(1'b0, MOVE_ROCK, 1'b0);
    step();
    step();
    @(negedge clk);
    checkOutput("rst_tx", tx, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_ready", move_ready, 1'b0);
    checkOutput("rst_done", frame_done, 1'b0);
    checkOutput("rst_err", err_invalid, 1'b0);
    check_en = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_rst", move_ready, 1'b1);

    // Paper from player 1: 0,1,0,1,0,1.
    run_literal(MOVE_PAPER, 1'b1, 6'b101010, 1'b0, "paper_p1");
    // Scissors from player 0: 0,0,1,0,1,1 with parity 1.
    run_literal(MOVE_SCISSORS, 1'b0, 6'b110100, 1'b0, "scis_p0");
    // A pulse while busy must not disturb the paper frame.
    run_literal(MOVE_PAPER, 1'b1, 6'b101010, 1'b1, "busy_pulse");
    step();
    @(negedge clk);
    checkOutput("no_extra_frame", busy, 1'b0);

    // Invalid move: error pulse next cycle, line stays idle.
    wait_idle();
    applyStimulus(1'b1, MOVE_INVALID, 1'b1);
    step();
    applyStimulus(1'b0, MOVE_ROCK, 1'b0);
    @(negedge clk);
    checkOutput("inv_err", err_invalid, 1'b1);
    checkOutput("inv_tx", tx, 1'b1);
    checkOutput("inv_busy", busy, 1'b0);
    step();
    @(negedge clk);
    checkOutput("inv_err_clear", err_invalid, 1'b0);

    // move_valid held 60 cycles with rock/player 0.
    wait_idle();
    snap = done_count;
    applyStimulus(1'b1, MOVE_ROCK, 1'b0);
    for (int c = 1; c < 60; c++) step();
    @(negedge clk);
    checkOutput("held_two_frames", (done_count - snap) == 2, 1'b1);
    checkOutput("held_third_busy", busy, 1'b1);
    step();
    applyStimulus(1'b0, MOVE_ROCK, 1'b0);

    // Reset at cycle 10 of a frame.
    wait_idle();
    applyStimulus(1'b1, MOVE_ROCK, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 1) applyStimulus(1'b0, MOVE_ROCK, 1'b0);
    end
    snap = done_count;
    rst = 1'b1;
    #1;
    checkOutput("abort_tx", tx, 1'b1);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_done", frame_done, 1'b0);
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_ready", move_ready, 1'b1);
    for (int c = 0; c < 30; c++) step();
    checkOutput("abort_no_done", done_count == snap, 1'b1);

    // Randomised traffic including held valids, invalid codes and resets.
    for (int i = 0; i < 600; i++) begin
      step();
      rst = ($urandom_range(0, 149) == 0);
      applyStimulus($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
    end
    step();
    rst = 1'b0;
    applyStimulus(1'b0, MOVE_ROCK, 1'b0);
    for (int c = 0; c < 40; c++) step();
    check_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
